// File: rtl/encoder_motion_controller.sv
// Closed-loop point-to-point move sequencer for one encoder-tracked motor axis.
// Optional soft position limits are enabled by defining SOFT_LIMIT_EN.
module encoder_motion_controller #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned TOLERANCE    = 0,
  parameter int unsigned BRAKE_CYCLES = 16,
  parameter int unsigned STALL_CYCLES = 1000
`ifdef SOFT_LIMIT_EN
  ,
  parameter int unsigned LIMIT_MIN    = 0,
  parameter int unsigned LIMIT_MAX    = 1023
`endif
) (
  input  logic             clock,
  input  logic             a_reset,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_target,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] coordinate,
  input  logic             encoder_error,
  input  logic             abort,
  input  logic             fault_clear,
  output logic             motor_en,
  output logic             motor_dir,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code
`ifdef SOFT_LIMIT_EN
  ,
  output logic             cmd_reject
`endif
);

  localparam int unsigned DW  = WIDTH + 1;
  localparam int unsigned SCW = $clog2(STALL_CYCLES + 1);
  localparam int unsigned BCW = $clog2(BRAKE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_BRAKE, S_DONE, S_FAULT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] coord_prev_q;
  logic [SCW-1:0]   stall_q, stall_d;
  logic [BCW-1:0]   brake_q, brake_d;
  logic             dir_d;
  logic [1:0]       code_d;
  logic             moved_c, arrived_c, active_c;
`ifdef SOFT_LIMIT_EN
  logic             reject_d;

  function automatic logic in_limits(input logic [WIDTH-1:0] v);
    return (32'(v) >= LIMIT_MIN) && (32'(v) <= LIMIT_MAX);
  endfunction
`endif

  // Unsigned distance, computed one bit wider so the subtraction cannot wrap.
  function automatic logic [DW-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [DW-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DW-1] ? -d : d;
  endfunction

  assign moved_c   = (coordinate != coord_prev_q);
  assign active_c  = (state_q == S_MOVE) || (state_q == S_BRAKE) || (state_q == S_DONE);
  // Overshoot counts as arrival; the direction chosen at acceptance is never reversed.
  assign arrived_c = (abs_diff(target_q, coordinate) <= DW'(TOLERANCE)) ||
                     (motor_dir ? (coordinate > target_q) : (coordinate < target_q));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    stall_d  = stall_q;
    brake_d  = brake_q;
    dir_d    = motor_dir;
    code_d   = fault_code;
`ifdef SOFT_LIMIT_EN
    reject_d = 1'b0;
`endif
    if (active_c && (abort || encoder_error)) begin
      state_d = S_FAULT;
      code_d  = abort ? 2'b11 : 2'b10;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
`ifdef SOFT_LIMIT_EN
            if (!in_limits(cmd_target)) begin
              reject_d = 1'b1;
            end else
`endif
            begin
              target_d = cmd_target;
              dir_d    = (cmd_target > coordinate);
              if (abs_diff(cmd_target, coordinate) <= DW'(TOLERANCE)) begin
                state_d = S_BRAKE;
                brake_d = '0;
              end else begin
                state_d = S_MOVE;
                stall_d = '0;
              end
            end
          end
        end
        S_MOVE: begin
          stall_d = moved_c ? '0 : stall_q + SCW'(1);
          if (!moved_c && (stall_q == SCW'(STALL_CYCLES - 1))) begin
            state_d = S_FAULT;
            code_d  = 2'b01;
          end
`ifdef SOFT_LIMIT_EN
          else if (!in_limits(coordinate)) begin
            state_d = S_FAULT;
            code_d  = 2'b01;
          end
`endif
          else if (arrived_c) begin
            state_d = S_BRAKE;
            brake_d = '0;
          end
        end
        S_BRAKE: begin
          if (brake_q == BCW'(BRAKE_CYCLES - 1)) begin
            state_d = S_DONE;
          end else begin
            brake_d = brake_q + BCW'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        S_FAULT: begin
          // A still-asserted abort re-arms the fault instead of releasing it.
          if (fault_clear) begin
            if (abort) begin
              code_d = 2'b11;
            end else begin
              state_d = S_IDLE;
              code_d  = 2'b00;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with the state change.
  always_ff @(posedge clock or posedge a_reset) begin
    if (a_reset) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      coord_prev_q <= '0;
      stall_q      <= '0;
      brake_q      <= '0;
      cmd_ready    <= 1'b1;
      motor_en     <= 1'b0;
      motor_dir    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= 2'b00;
`ifdef SOFT_LIMIT_EN
      cmd_reject   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      coord_prev_q <= coordinate;
      stall_q      <= stall_d;
      brake_q      <= brake_d;
      cmd_ready    <= (state_d == S_IDLE);
      motor_en     <= (state_d == S_MOVE);
      motor_dir    <= dir_d;
      busy         <= (state_d == S_MOVE) || (state_d == S_BRAKE) || (state_d == S_DONE);
      done         <= (state_d == S_DONE);
      fault        <= (state_d == S_FAULT);
      fault_code   <= code_d;
`ifdef SOFT_LIMIT_EN
      cmd_reject   <= reject_d;
`endif
    end
  end

endmodule
